// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: Philips I2S serializer running on the DAC PLL output clock.
// Waits for a synchronized PLL lock, divides clk down to BCLK/LRCK and shifts
// stereo samples out MSB-first, one BCLK after each LRCK edge. Samples arrive
// through a single-entry valid/ready buffer that is drained at every frame start.
module i2s_dac_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrck,
  output logic              sdata,
  output logic              underrun,
  output logic              active
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic r_lockMeta;
  logic r_lockS;

  logic [DIV_W-1:0] r_divCnt;
  logic [BIT_W-1:0] r_bitIdx;
  logic [DIV_W-1:0] w_nextDiv;
  logic [BIT_W-1:0] w_nextBit;
  logic [BIT_W-1:0] w_nextOffset;
  logic [DATA_W-1:0] w_nextSample;
  logic             w_nextData;
  logic             w_nextRun;

  logic              r_bufFull;
  logic [DATA_W-1:0] r_bufL;
  logic [DATA_W-1:0] r_bufR;
  logic [DATA_W-1:0] r_frameL;
  logic [DATA_W-1:0] r_frameR;

  logic r_bclk;
  logic r_lrck;
  logic r_sdata;

  logic w_frameStart;
  logic w_transfer;

  // Bring the asynchronous PLL lock into the clk domain through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lockMeta <= 1'b0;
      r_lockS    <= 1'b0;
    end else begin
      r_lockMeta <= pll_lock;
      r_lockS    <= r_lockMeta;
    end
  end

  // State register for the IDLE/RUN controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Run whenever synchronized lock is present; any lock loss drops to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (r_lockS)  w_nextState = RUN;
      RUN:  if (!r_lockS) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_nextRun = (w_nextState == RUN);

  // Next divider/bit position; a fresh RUN period always starts at bit 0, div 0.
  always_comb begin
    w_nextDiv = '0;
    w_nextBit = '0;
    if (r_state == RUN && w_nextRun) begin
      if (r_divCnt == DIV_LAST) begin
        w_nextDiv = '0;
        w_nextBit = (r_bitIdx == BIT_LAST) ? '0 : r_bitIdx + 1'b1;
      end else begin
        w_nextDiv = r_divCnt + 1'b1;
        w_nextBit = r_bitIdx;
      end
    end
  end

  // Serial bit for the upcoming cycle: MSB one BCLK after the slot boundary.
  always_comb begin
    w_nextOffset = (w_nextBit >= SLOT_START) ? w_nextBit - SLOT_START : w_nextBit;
    w_nextSample = (w_nextBit >= SLOT_START) ? r_frameR : r_frameL;
    w_nextData   = 1'b0;
    if (w_nextOffset != '0 && w_nextOffset <= DATA_LAST) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (DATA_LAST - w_nextOffset == BIT_W'(i)) w_nextData = w_nextSample[i];
      end
    end
  end

  // Counters and registered I2S pins, computed one cycle ahead so the pins
  // always match the current divider and bit position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
      r_bitIdx <= '0;
      r_bclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
    end else begin
      r_divCnt <= w_nextDiv;
      r_bitIdx <= w_nextBit;
      r_bclk   <= w_nextRun & (w_nextDiv >= DIV_HALF);
      r_lrck   <= w_nextRun & (w_nextBit >= SLOT_START);
      r_sdata  <= w_nextRun & w_nextData;
    end
  end

  assign active       = (r_state == RUN);
  assign s_ready      = active & ~r_bufFull;
  assign w_transfer   = s_valid & s_ready;
  assign w_frameStart = active && (r_divCnt == '0) && (r_bitIdx == '0);
  assign underrun     = w_frameStart & ~r_bufFull;

  // Input buffer and frame register; the frame takes the buffer (or silence)
  // only at frame start, and leaving RUN throws away anything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bufFull <= 1'b0;
      r_bufL    <= '0;
      r_bufR    <= '0;
      r_frameL  <= '0;
      r_frameR  <= '0;
    end else if (!w_nextRun) begin
      r_bufFull <= 1'b0;
    end else begin
      if (w_frameStart) begin
        if (r_bufFull) begin
          r_frameL  <= r_bufL;
          r_frameR  <= r_bufR;
          r_bufFull <= 1'b0;
        end else begin
          r_frameL <= '0;
          r_frameR <= '0;
        end
      end
      if (w_transfer) begin
        r_bufFull <= 1'b1;
        r_bufL    <= s_left;
        r_bufR    <= s_right;
      end
    end
  end

  assign bclk  = r_bclk;
  assign lrck  = r_lrck;
  assign sdata = r_sdata;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized bench for the I2S serializer. A cycle-level
// reference model predicts every pin and queues the expected serial frame at
// each frame start; a separate monitor deserializes sdata on BCLK rising edges
// and scores each completed frame against the queue.
module tb_i2s_dac_tx;

  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int BCLK_DIV   = 4;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int FRAME_CYC  = FRAME_BITS * BCLK_DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pll_lock;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              bclk;
  logic              lrck;
  logic              sdata;
  logic              underrun;
  logic              active;

  int vectors     = 0;
  int miscompares = 0;

  logic [FRAME_BITS-1:0] expFrames[$];

  i2s_dac_tx #(
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W),
    .BCLK_DIV(BCLK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pll_lock(pll_lock),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_left  (s_left),
    .s_right (s_right),
    .bclk    (bclk),
    .lrck    (lrck),
    .sdata   (sdata),
    .underrun(underrun),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Serial image of one frame: each sample sits one bit below the top of its slot.
  function automatic logic [FRAME_BITS-1:0] frameWord(input logic [DATA_W-1:0] l,
                                                      input logic [DATA_W-1:0] r);
    logic [SLOT_W-1:0] sl;
    logic [SLOT_W-1:0] sr;
    sl = SLOT_W'(l) << (SLOT_W - 1 - DATA_W);
    sr = SLOT_W'(r) << (SLOT_W - 1 - DATA_W);
    return {sl, sr};
  endfunction

  // Offer one sample pair and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    bit accepted;
    int waited;
    accepted = 1'b0;
    waited   = 0;
    s_left   = l;
    s_right  = r;
    s_valid  = 1'b1;
    while (!accepted && waited < 3 * FRAME_CYC) begin
      @(negedge clk);
      accepted = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    s_valid = 1'b0;
    checkOutput("accept", 64'(accepted), 64'd1);
  endtask

  logic [2:0]            lockHist;
  int                    phase;
  bit                    modelFull;
  logic [DATA_W-1:0]     bufL;
  logic [DATA_W-1:0]     bufR;
  logic [FRAME_BITS-1:0] curWord;

  // Reference model: active follows pll_lock three clocks late; while active,
  // every pin is a plain function of the cycle count since RUN began.
  always @(negedge clk) begin : model
    int                    bitIdx;
    bit                    frameStart;
    bit                    expReady;
    bit                    expUnderrun;
    logic [FRAME_BITS-1:0] shifted;
    if (rst) begin
      lockHist  = '0;
      phase     = 0;
      modelFull = 1'b0;
      curWord   = '0;
      expFrames.delete();
      checkOutput("rst_active", 64'(active), 64'd0);
      checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_bclk", 64'(bclk), 64'd0);
      checkOutput("rst_lrck", 64'(lrck), 64'd0);
      checkOutput("rst_sdata", 64'(sdata), 64'd0);
      checkOutput("rst_underrun", 64'(underrun), 64'd0);
    end else begin
      if (!lockHist[2]) begin
        phase     = 0;
        modelFull = 1'b0;
        checkOutput("idle_active", 64'(active), 64'd0);
        checkOutput("idle_s_ready", 64'(s_ready), 64'd0);
        checkOutput("idle_bclk", 64'(bclk), 64'd0);
        checkOutput("idle_lrck", 64'(lrck), 64'd0);
        checkOutput("idle_sdata", 64'(sdata), 64'd0);
        checkOutput("idle_underrun", 64'(underrun), 64'd0);
      end else begin
        bitIdx      = (phase / BCLK_DIV) % FRAME_BITS;
        frameStart  = (phase % FRAME_CYC) == 0;
        expReady    = !modelFull;
        expUnderrun = frameStart && !modelFull;
        if (frameStart) begin
          curWord   = modelFull ? frameWord(bufL, bufR) : '0;
          modelFull = 1'b0;
          expFrames.push_back(curWord);
        end
        shifted = curWord >> (FRAME_BITS - 1 - bitIdx);
        checkOutput("active", 64'(active), 64'd1);
        checkOutput("s_ready", 64'(s_ready), 64'(expReady));
        checkOutput("bclk", 64'(bclk), 64'((phase % BCLK_DIV) >= BCLK_DIV / 2));
        checkOutput("lrck", 64'(lrck), 64'(bitIdx >= SLOT_W));
        checkOutput("sdata", 64'(sdata), 64'(shifted[0]));
        checkOutput("underrun", 64'(underrun), 64'(expUnderrun));
        if (s_valid && expReady) begin
          modelFull = 1'b1;
          bufL      = s_left;
          bufR      = s_right;
        end
        phase++;
      end
      lockHist = {lockHist[1:0], pll_lock};
    end
  end

  logic                  prevBclk;
  int                    nbits;
  logic [FRAME_BITS-1:0] gotWord;
  logic [FRAME_BITS-1:0] gotLr;

  // Monitor: rebuild each frame from sdata/lrck at BCLK rising edges and
  // score it against the frame queued by the model.
  always @(negedge clk) begin : monitor
    logic [FRAME_BITS-1:0] expWord;
    if (rst) begin
      prevBclk = 1'b0;
      nbits    = 0;
    end else if (!active) begin
      prevBclk = 1'b0;
      nbits    = 0;
      while (expFrames.size() > 0) void'(expFrames.pop_front());
    end else begin
      if (bclk && !prevBclk) begin
        gotWord = {gotWord[FRAME_BITS-2:0], sdata};
        gotLr   = {gotLr[FRAME_BITS-2:0], lrck};
        nbits++;
        if (nbits == FRAME_BITS) begin
          checkOutput("frame_pending", 64'(expFrames.size()), 64'd1);
          if (expFrames.size() > 0) begin
            expWord = expFrames.pop_front();
            checkOutput("frame_data", 64'(gotWord), 64'(expWord));
            checkOutput("frame_lrck", 64'(gotLr), 64'({{SLOT_W{1'b0}}, {SLOT_W{1'b1}}}));
          end
          nbits = 0;
        end
      end
      prevBclk = bclk;
    end
  end

  // Stimulus: reset under lock, fixed and random samples, gaps that force
  // underruns, and lock drops late in the frame with a sample still buffered.
  initial begin
    pll_lock = 1'b1;
    s_valid  = 1'b0;
    s_left   = '0;
    s_right  = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    repeat (300) @(posedge clk);
    #1;
    applyStimulus(24'hA5A5A5, 24'h5A5A5A);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()));
    end

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 400)) @(posedge clk);
      #1;
      applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()));
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()));
      applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()));
      repeat (130 + $urandom_range(0, 110)) @(posedge clk);
      #1 pll_lock = 1'b0;
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1 pll_lock = 1'b1;
      repeat (300) @(posedge clk);
      #1;
    end

    applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()));
    repeat (600) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
Audio serializer directly downstream of the DAC PLL. It runs on the PLL output clock and stays idle until the PLL lock indication is synchronized. It then derives BCLK and LRCK by integer division and shifts stereo samples out MSB-first in Philips I2S format. Samples enter through a one-entry valid/ready buffer, so the upstream sample source can run without frame-exact timing.

Parameters:
DATA_W, 24, sample width per channel; must satisfy 1 <= DATA_W <= SLOT_W-1.
SLOT_W, 32, BCLK periods per channel slot; one frame is 2*SLOT_W BCLK periods.
BCLK_DIV, 4, clk cycles per BCLK period; even, >= 2.

Ports:
clk  in  1  PLL output clock (the PLL's clkout0); all logic is in this domain.
rst  in  1  asynchronous, active-high reset.
pll_lock  in  1  PLL lock, asynchronous to clk; double-flopped internally to lock_s.
s_valid  in  1  sample pair valid.
s_ready  out  1  buffer can accept a sample pair.
s_left  in  DATA_W  left sample, two's complement.
s_right  in  DATA_W  right sample, two's complement.
bclk  out  1  bit clock, registered.
lrck  out  1  word select: 0 = left, 1 = right; registered.
sdata  out  1  serial data, registered.
underrun  out  1  one-clk pulse when a frame starts with an empty buffer.
active  out  1  high while in RUN.

Behaviour:
- Reset (asynchronous): all outputs are 0. FSM goes to IDLE, buffer is empty, all counters are 0.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN on the first cycle lock_s = 1.
  - RUN -> IDLE on any cycle lock_s = 0.
- IDLE: bclk, lrck, sdata, s_ready and active are held at 0. Counters are cleared and the buffer is emptied (its contents are discarded).
- Divider div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk = 0 while div_cnt < BCLK_DIV/2, else 1.
  - A "bit tick" occurs at div_cnt = 0, which is the bclk falling edge.
- Bit counter bit_idx counts 0..2*SLOT_W-1 and advances on each bit tick.
  - Frame start is the bit tick with bit_idx = 0.
  - The first bit tick occurs in the first RUN cycle.
- lrck = 1 when bit_idx >= SLOT_W, else 0. It changes only on bit ticks.
- sdata (I2S one-bit delay): within each slot, with offset o = bit_idx mod SLOT_W:
  - o = 1..DATA_W: sdata = sample[DATA_W-o], i.e. MSB at o = 1.
  - Any other o: sdata = 0.
  - sdata changes only on bit ticks.
- Buffer: single entry holding {left, right}.
  - s_ready = active & ~buf_full.
  - A transfer happens when s_valid & s_ready are both high; buf_full sets the next cycle.
- Frame load, at frame start:
  - If buf_full: the frame register takes the buffer contents, buf_full clears, and s_ready rises the next cycle.
  - If the buffer is empty: the frame register is loaded with zeros and underrun pulses for exactly that one cycle.
  - A transfer in the same cycle as an empty-buffer frame start fills the buffer for the next frame; there is no bypass.
- The frame register is stable for the whole frame. Right-channel bits come from the same loaded pair as the left.
- Lock loss mid-frame: the next cycle enters IDLE. All outputs are 0, the frame is abandoned, and underrun is not asserted.
  - On relock, the frame restarts at bit_idx = 0.
- Latency: pll_lock rising -> active high 3 clk later (2 synchronizer stages + state register). bclk, lrck and sdata update in the same registered cycle as active.
- Frame period = 2*SLOT_W*BCLK_DIV clk cycles (256 at defaults).

Test Plan (defaults: DATA_W=24, SLOT_W=32, BCLK_DIV=4):
1. Assert rst with pll_lock = 1 -> all outputs 0. Release rst -> active and s_ready go high on the 3rd clk; first frame carries zeros and underrun pulses once.
2. While active, hold s_valid with s_left=0xA5A5A5, s_right=0x5A5A5A -> next frame sdata sampled on bclk rising edges reads 0, then 1010 0101... (24 bits), then 7 zeros while lrck=0; the same pattern with 0x5A5A5A while lrck=1. underrun stays 0.
3. Continuous back-to-back valid -> s_ready drops after each accept and reasserts 1 clk after each frame start. Exactly one transfer per 256 clk. No underrun.
4. Skip one sample -> underrun pulses exactly 1 cycle at that frame start, the frame sends all zeros, and the next supplied sample plays in the following frame.
5. Drop pll_lock mid-right-slot -> within 3 clk active=0 and bclk=lrck=sdata=0; a pending buffered sample is discarded. Relock -> frame restarts with lrck=0 and a fresh underrun.
6. Measure bclk and lrck periods -> bclk = 4 clk at 50% duty; lrck = 256 clk at 50% duty, toggling only on bclk falling edges.
